// File: rtl/uart_tx_scheduler.sv
// Round-robin arbiter with optional multi-byte lock feeding a single 8N1 UART
// transmitter; bit timing comes from a divisor latched when each byte is accepted.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   S_IDLE  | line idle high, arbitration open, one byte accepted per grant
//   S_START | start bit (low) for D cycles
//   S_DATA  | 8 data bits, LSB first, D cycles each
//   S_STOP  | stop bit (high) for D cycles, then back to S_IDLE
module uart_tx_scheduler #(
  parameter int P_NUM_REQ   = 4,
  parameter int P_DIV_WIDTH = 16,
  parameter int P_ID_WIDTH  = $clog2(P_NUM_REQ)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [P_DIV_WIDTH-1:0] i_div,
  input  logic [P_NUM_REQ-1:0]   i_req_valid,
  input  logic [8*P_NUM_REQ-1:0] i_req_data,
  input  logic [P_NUM_REQ-1:0]   i_req_last,
  output logic [P_NUM_REQ-1:0]   o_req_ready,
  output logic [P_ID_WIDTH-1:0]  o_grant_id,
  output logic                   o_busy,
  output logic                   o_tx
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t                 state;
  logic [P_DIV_WIDTH-1:0] div_q;
  logic [P_DIV_WIDTH-1:0] bit_cnt;
  logic [2:0]             bit_idx;
  logic [2:0]             next_idx;
  logic [7:0]             data_q;
  logic                   locked;
  logic [P_ID_WIDTH-1:0]  lock_id;
  logic [P_ID_WIDTH-1:0]  rr_ptr;
  logic [P_ID_WIDTH-1:0]  next_ptr;
  logic                   found;
  logic [P_ID_WIDTH-1:0]  win_id;
  logic                   bit_done;
  int                     idx;

  assign bit_done = (bit_cnt == div_q - P_DIV_WIDTH'(1));
  assign next_idx = bit_idx + 3'd1;
  assign next_ptr = (win_id == P_ID_WIDTH'(P_NUM_REQ - 1)) ? '0 : win_id + P_ID_WIDTH'(1);

  // While locked only the lock holder may win; otherwise search upward from rr_ptr.
  always_comb begin
    found       = 1'b0;
    win_id      = '0;
    o_req_ready = '0;
    idx         = 0;
    if (state == S_IDLE) begin
      if (locked) begin
        if (i_req_valid[lock_id]) begin
          found  = 1'b1;
          win_id = lock_id;
        end
      end else begin
        for (int i = 0; i < P_NUM_REQ; i++) begin
          idx = int'(rr_ptr) + i;
          if (idx >= P_NUM_REQ) idx = idx - P_NUM_REQ;
          if (!found && i_req_valid[idx]) begin
            found  = 1'b1;
            win_id = P_ID_WIDTH'(idx);
          end
        end
      end
      if (found) o_req_ready[win_id] = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      o_tx       <= 1'b1;
      o_busy     <= 1'b0;
      o_grant_id <= '0;
      locked     <= 1'b0;
      lock_id    <= '0;
      rr_ptr     <= '0;
      div_q      <= P_DIV_WIDTH'(2);
      bit_cnt    <= '0;
      bit_idx    <= '0;
      data_q     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (found) begin
            data_q     <= i_req_data[8*win_id +: 8];
            div_q      <= (i_div < P_DIV_WIDTH'(2)) ? P_DIV_WIDTH'(2) : i_div;
            o_grant_id <= win_id;
            rr_ptr     <= next_ptr;
            locked     <= ~i_req_last[win_id];
            lock_id    <= win_id;
            bit_cnt    <= '0;
            o_tx       <= 1'b0;
            o_busy     <= 1'b1;
            state      <= S_START;
          end
        end
        S_START: begin
          if (bit_done) begin
            bit_cnt <= '0;
            bit_idx <= '0;
            o_tx    <= data_q[0];
            state   <= S_DATA;
          end else begin
            bit_cnt <= bit_cnt + P_DIV_WIDTH'(1);
          end
        end
        S_DATA: begin
          if (bit_done) begin
            bit_cnt <= '0;
            if (bit_idx == 3'd7) begin
              o_tx  <= 1'b1;
              state <= S_STOP;
            end else begin
              bit_idx <= next_idx;
              o_tx    <= data_q[next_idx];
            end
          end else begin
            bit_cnt <= bit_cnt + P_DIV_WIDTH'(1);
          end
        end
        S_STOP: begin
          if (bit_done) begin
            bit_cnt <= '0;
            o_busy  <= 1'b0;
            state   <= S_IDLE;
          end else begin
            bit_cnt <= bit_cnt + P_DIV_WIDTH'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench: a queue-level arbitration model predicts grant order, data and
// bit period; a monitor checks every accepted frame cycle by cycle on o_tx/o_busy.
module tb_uart_tx_scheduler;
  localparam int NREQ   = 4;
  localparam int DW     = 16;
  localparam int IDW    = 2;
  localparam int BUDGET = 20000;

  logic            clock = 1'b0;
  logic            reset;
  logic [DW-1:0]   i_div;
  logic [NREQ-1:0] i_req_valid;
  logic [8*NREQ-1:0] i_req_data;
  logic [NREQ-1:0] i_req_last;
  logic [NREQ-1:0] o_req_ready;
  logic [IDW-1:0]  o_grant_id;
  logic            o_busy;
  logic            o_tx;

  uart_tx_scheduler #(.P_NUM_REQ(NREQ), .P_DIV_WIDTH(DW), .P_ID_WIDTH(IDW)) dut (
    .clock(clock), .reset(reset), .i_div(i_div), .i_req_valid(i_req_valid),
    .i_req_data(i_req_data), .i_req_last(i_req_last), .o_req_ready(o_req_ready),
    .o_grant_id(o_grant_id), .o_busy(o_busy), .o_tx(o_tx));

  always #5 clock = ~clock;

  typedef struct {logic [7:0] data; logic last;} src_t;
  typedef struct {int id; logic [7:0] data; int d;} exp_t;

  src_t src_q[NREQ][$];
  exp_t exp_q[$];
  int   div_list[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   m_ptr    = 0;
  int   m_lock   = -1;
  bit   mon_en   = 1'b0;
  bit   mon_busy = 1'b0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic add_byte(int k, logic [7:0] d, logic l);
    src_t s;
    s.data = d;
    s.last = l;
    src_q[k].push_back(s);
  endtask

  // Reference: replay the per-source queues through round-robin + lock rules.
  task automatic build_expect();
    src_t m_q[NREQ][$];
    int total = 0;
    for (int k = 0; k < NREQ; k++) begin
      m_q[k] = src_q[k];
      total += m_q[k].size();
    end
    for (int n = 0; n < total; n++) begin
      int   k = -1;
      src_t s;
      exp_t e;
      if (m_lock >= 0) begin
        if (m_q[m_lock].size() > 0) k = m_lock;
      end else begin
        for (int i = 0; i < NREQ; i++) begin
          int j = (m_ptr + i) % NREQ;
          if (k < 0 && m_q[j].size() > 0) k = j;
        end
      end
      if (k < 0) break;
      s = m_q[k].pop_front();
      e.id = k;
      e.data = s.data;
      e.d = (div_list[n] < 2) ? 2 : div_list[n];
      exp_q.push_back(e);
      m_ptr = (k + 1) % NREQ;
      m_lock = s.last ? -1 : k;
    end
  endtask

  task automatic drive_inputs();
    for (int k = 0; k < NREQ; k++) begin
      if (src_q[k].size() > 0) begin
        i_req_valid[k] = 1'b1;
        i_req_data[8*k +: 8] = src_q[k][0].data;
        i_req_last[k] = src_q[k][0].last;
      end else begin
        i_req_valid[k] = 1'b0;
        i_req_last[k] = 1'b0;
      end
    end
  endtask

  function automatic bit any_src();
    bit r = 1'b0;
    for (int k = 0; k < NREQ; k++) if (src_q[k].size() > 0) r = 1'b1;
    return r;
  endfunction

  task automatic run_phase(string name);
    int n_acc = 0;
    int cyc = 0;
    logic [NREQ-1:0] acc;
    build_expect();
    i_div = DW'(div_list[0]);
    drive_inputs();
    while ((any_src() || exp_q.size() != 0 || mon_busy) && cyc < BUDGET) begin
      @(negedge clock);
      acc = o_req_ready;
      @(posedge clock);
      #1;
      cyc++;
      if (acc != '0) begin
        for (int k = 0; k < NREQ; k++)
          if (acc[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
        n_acc++;
        i_div = (n_acc < div_list.size()) ? DW'(div_list[n_acc]) : DW'($urandom_range(0, 15));
        drive_inputs();
      end
    end
    chk({name, "_completed"}, (cyc < BUDGET), 1);
    repeat (2) @(posedge clock);
    #1;
    div_list.delete();
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    m_ptr = 0;
    m_lock = -1;
    @(posedge clock);
    #1;
  endtask

  // Monitor: one expected entry per acceptance, then 10*D cycles of waveform.
  initial begin
    exp_t e;
    int   id;
    int   b;
    forever begin
      @(negedge clock);
      if (mon_en) begin
        if (o_req_ready != '0) begin
          mon_busy = 1'b1;
          chk("ready_onehot", 32'($onehot(o_req_ready)), 1);
          id = 0;
          for (int k = 0; k < NREQ; k++) if (o_req_ready[k]) id = k;
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_accept: got requester %0d expected none at %0t", id, $time);
          end else begin
            e = exp_q.pop_front();
            chk("grant_order", id, e.id);
            for (int c = 1; c <= 10 * e.d; c++) begin
              @(negedge clock);
              b = (c - 1) / e.d;
              if (c == 1) chk("grant_id", 32'(o_grant_id), e.id);
              chk("tx_bit", 32'(o_tx), (b == 0) ? 0 : (b <= 8) ? 32'(e.data[b-1]) : 1);
              chk("busy_frame", 32'(o_busy), 1);
              chk("ready_frame", 32'(o_req_ready), 0);
            end
          end
          mon_busy = 1'b0;
        end else begin
          chk("tx_idle", 32'(o_tx), 1);
          chk("busy_idle", 32'(o_busy), 0);
        end
      end
    end
  end

  initial begin
    int cyc;
    int total;
    reset = 1'b1;
    i_div = '0;
    i_req_valid = '0;
    i_req_data = '0;
    i_req_last = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_tx", 32'(o_tx), 1);
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_grant", 32'(o_grant_id), 0);
    chk("rst_ready", 32'(o_req_ready), 0);
    reset = 1'b0;
    @(posedge clock);
    #1;
    mon_en = 1'b1;

    add_byte(0, 8'hA5, 1'b1);
    div_list = '{4};
    run_phase("single_byte");

    apply_reset();
    add_byte(0, 8'h5A, 1'b1);
    add_byte(0, 8'h0F, 1'b1);
    add_byte(1, 8'h81, 1'b1);
    add_byte(2, 8'h42, 1'b1);
    add_byte(3, 8'hC3, 1'b1);
    div_list = '{2, 2, 2, 2, 2};
    run_phase("round_robin");

    add_byte(2, 8'h11, 1'b0);
    add_byte(2, 8'h22, 1'b1);
    add_byte(0, 8'h33, 1'b1);
    div_list = '{3, 3, 3};
    run_phase("lock");

    add_byte(1, 8'h96, 1'b1);
    add_byte(3, 8'h69, 1'b1);
    div_list = '{0, 1};
    run_phase("div_clamp");

    add_byte(2, 8'hE1, 1'b1);
    add_byte(2, 8'h1E, 1'b1);
    div_list = '{8, 3};
    run_phase("div_change");

    for (int p = 0; p < 4; p++) begin
      total = 0;
      for (int k = 0; k < NREQ; k++) begin
        int n = $urandom_range(0, 3);
        for (int j = 0; j < n; j++)
          add_byte(k, 8'($urandom), (j == n - 1) ? 1'b1 : 1'($urandom_range(0, 1)));
        total += n;
      end
      if (total == 0) begin
        add_byte(0, 8'($urandom), 1'b1);
        total = 1;
      end
      for (int n = 0; n < total; n++) div_list.push_back($urandom_range(0, 6));
      run_phase("random");
    end

    // Abort a frame during data bit 3 and confirm a clean restart from pointer 0.
    mon_en = 1'b0;
    i_div = DW'(4);
    i_req_data[15:8] = 8'hF7;
    i_req_last[1] = 1'b1;
    i_req_valid = 4'b0010;
    cyc = 0;
    do begin
      @(negedge clock);
      cyc++;
    end while (!o_req_ready[1] && cyc < 100);
    chk("midrst_accept", 32'(o_req_ready[1]), 1);
    @(posedge clock);
    #1;
    i_req_valid = '0;
    repeat (17) @(posedge clock);
    @(negedge clock);
    chk("midrst_bit3", 32'(o_tx), 0);
    chk("midrst_busy_before", 32'(o_busy), 1);
    chk("midrst_grant_before", 32'(o_grant_id), 1);
    reset = 1'b1;
    @(negedge clock);
    chk("midrst_tx", 32'(o_tx), 1);
    chk("midrst_busy", 32'(o_busy), 0);
    chk("midrst_grant", 32'(o_grant_id), 0);
    reset = 1'b0;
    m_ptr = 0;
    m_lock = -1;
    @(posedge clock);
    #1;
    mon_en = 1'b1;
    add_byte(1, 8'hC3, 1'b1);
    add_byte(0, 8'h3C, 1'b1);
    div_list = '{3, 3};
    run_phase("after_reset");

    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
- Shares one 8N1 UART transmit lane between P_NUM_REQ byte sources.
- Uses round-robin arbitration with optional multi-byte lock: the grant is held until a byte flagged last has been sent.
- Generates its own per-bit timing from a runtime divisor (clock cycles per bit) and drives the serial line directly.
- Sits between the protocol/packet clients and the UART TX pin, and replaces a free-running baud clock with a frame-synchronous bit counter.

Parameters:
- P_NUM_REQ, 4, number of requesters (2..8).
- P_DIV_WIDTH, 16, width of the divisor input.
- P_ID_WIDTH, $clog2(P_NUM_REQ), width of the grant index.

Ports:
- clock  input  1  system clock.
- reset  input  1  synchronous reset, active high.
- i_div  input  P_DIV_WIDTH  clock cycles per UART bit; sampled at byte acceptance.
- i_req_valid  input  P_NUM_REQ  per-requester byte valid.
- i_req_data  input  8*P_NUM_REQ  per-requester byte; requester k uses bits [8k+7:8k].
- i_req_last  input  P_NUM_REQ  per-requester: 1 = release the grant after this byte.
- o_req_ready  output  P_NUM_REQ  per-requester accept strobe; at most one bit high.
- o_grant_id  output  P_ID_WIDTH  index of the most recently accepted requester.
- o_busy  output  1  a frame is being transmitted.
- o_tx  output  1  UART serial output, idle high.

Behaviour:
- Reset values (synchronous, active high):
  - o_tx=1, o_busy=0, o_grant_id=0, o_req_ready=0.
  - State IDLE, lock flag cleared, round-robin pointer 0.
- States: IDLE, START, DATA, STOP.
- Acceptance, IDLE only:
  - o_req_ready is combinational from state and the valid inputs.
  - Unlocked: winner is the first requester k with i_req_valid[k]=1, searching upward from the pointer and wrapping modulo P_NUM_REQ.
  - Locked: only the locked requester is eligible; others are ignored even if valid. If the locked requester drops valid, the scheduler waits in IDLE indefinitely.
  - A transfer happens in the cycle where o_req_ready[k]=1. That cycle it latches the byte, latches the divisor, sets o_grant_id=k and sets the pointer to (k+1) mod P_NUM_REQ.
  - Lock update in that cycle: if i_req_last[k]=0, lock to k; if 1, clear the lock.
  - No valid eligible requester means no transfer, and the scheduler stays in IDLE.
- Divisor: latched value D = max(i_div, 2). Changes to i_div mid-frame have no effect.
- Frame timing, with acceptance in cycle T:
  - START: o_tx=0 for cycles T+1 .. T+D.
  - DATA: 8 bits, LSB first; bit n is driven for cycles T+(n+1)*D+1 .. T+(n+2)*D.
  - STOP: o_tx=1 for cycles T+9*D+1 .. T+10*D.
  - State is IDLE at T+10*D+1, where the next acceptance may occur.
  - Back-to-back frame period: 10*D+1 cycles. o_tx stays 1 in IDLE.
- o_busy=1 exactly for cycles T+1 .. T+10*D.
- Counters:
  - Bit-cycle counter: P_DIV_WIDTH bits; counts 0..D-1, then wraps and advances the bit.
  - Bit index: 3 bits; counts 0..7 in DATA.
- o_tx and o_busy are registered; there are no combinational paths from inputs to o_tx.
- Reset mid-frame: the next cycle has o_tx=1, state IDLE, lock cleared and pointer 0. The aborted byte is dropped and not retransmitted.
- Simultaneous events: requests arriving during START, DATA or STOP are not accepted. They are evaluated in the IDLE cycle using the pointer value at that time.

Test Plan:
- Single byte: requester 0, data=0xA5, last=1, i_div=4, accepted at T → o_tx = 0 for 4 cycles; then bits 1,0,1,0,0,1,0,1 at 4 cycles each; then 1 for 4 cycles. o_busy high for 40 cycles; IDLE at T+41.
- Round-robin: all 4 requesters valid continuously, last=1, i_div=2 → grants accepted in order 0,1,2,3,0, spaced 21 cycles apart. o_grant_id follows the same sequence.
- Lock: requester 2 sends 0x11 (last=0) then 0x22 (last=1) while requester 0 is valid throughout → grants in order 2,2,0. Requester 0's byte starts only after 0x22's stop bit.
- Divisor clamp: i_div=0 and i_div=1 → each bit lasts 2 cycles and the frame lasts 20 cycles.
- i_div changed from 8 to 3 mid-frame → the current frame keeps 8-cycle bits; the next accepted frame uses 3-cycle bits.
- reset asserted during DATA bit 3 → next cycle o_tx=1, o_busy=0, o_grant_id=0. A new request from requester 1 is then accepted with pointer 0, so requester 0 wins if both are valid.
